// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential 8x8 multiplier built on a 4x4 core.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MULT_STEPS = 4;

  // Weight of each nibble partial product: lo*lo, lo*hi, hi*lo, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = 4'd0;
      2'd1:    step_shift = 4'd4;
      2'd2:    step_shift = 4'd4;
      default: step_shift = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational 4x4 unsigned multiplier (shift-and-add of the B bits).
module multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Sum
);

  always_comb begin
    Sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (B[i]) Sum = Sum + ({4'b0, A} << i);
    end
  end

endmodule

// File: rtl/mult8_seq.sv
// Sequential 8x8 multiplier: one shared 4x4 multiplier, four accumulate steps,
// valid/ready handshakes on operand and result sides.
module mult8_seq
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  localparam logic [1:0] STEP_LAST = 2'(MULT_STEPS - 1);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  pp;

  // step[1] picks the a nibble, step[0] the b nibble.
  assign mul_a = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign mul_b = step_q[0] ? b_q[7:4] : b_q[3:0];

  multiplier u_mul (
    .A   (mul_a),
    .B   (mul_b),
    .Sum (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)            state_d = MUL;
      MUL:     if (step_q == STEP_LAST) state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    step_d = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          acc_d  = '0;
          step_d = '0;
        end
      end
      MUL: begin
        acc_d  = acc_q + ({8'b0, pp} << step_shift(step_q));
        step_d = step_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      step_q <= step_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

  assign product = acc_q;

endmodule

// File: tb/tb_mult8_seq.sv
// Directed plus random bench for mult8_seq against an arithmetic reference.
module tb_mult8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Running sum of the nibble partial products through step s.
  function automatic int partial_sum(input int av, input int bv, input int s);
    int alo, ahi, blo, bhi;
    int pps[4];
    alo = av % 16; ahi = av / 16;
    blo = bv % 16; bhi = bv / 16;
    pps[0] = alo * blo;
    pps[1] = alo * bhi * 16;
    pps[2] = ahi * blo * 16;
    pps[3] = ahi * bhi * 256;
    partial_sum = 0;
    for (int j = 0; j <= s; j++) partial_sum += pps[j];
  endfunction

  task automatic do_op(input logic [7:0] a_i, input logic [7:0] b_i, input int hold,
                       input bit pulse, input bit trace);
    int exp_p;
    exp_p = int'(a_i) * int'(b_i);
    @(negedge clk);
    a = a_i; b = b_i; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_mul", busy, 1);
    chk("in_ready_mul", in_ready, 0);
    chk("acc_cleared", product, 0);
    for (int s = 0; s < 4; s++) begin
      if (pulse) begin in_valid = 1'b1; a = ~a_i; b = 8'h5a; end
      @(negedge clk);
      if (trace) chk("acc_step", product, partial_sum(a_i, b_i, s));
      if (s < 3) begin
        chk("out_valid_early", out_valid, 0);
        chk("busy_run", busy, 1);
      end
    end
    in_valid = 1'b0;
    chk("out_valid_done", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("product", product, exp_p);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, exp_p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_in_ready", in_ready, 1);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
    if (pulse) begin
      repeat (3) @(negedge clk);
      chk("no_second_result", out_valid, 0);
      chk("still_idle", in_ready, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 0, 1'b0, 1'b1);
    do_op(8'hFF, 8'hFF, 0, 1'b0, 1'b1);
    do_op(8'h12, 8'h34, 0, 1'b0, 1'b1);
    do_op(8'hA5, 8'h3C, 3, 1'b0, 1'b0);
    do_op(8'h5B, 8'hC7, 0, 1'b1, 1'b0);

    // Abort during step 2.
    @(negedge clk);
    a = 8'hE3; b = 8'h9D; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h07, 8'h09, 0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
